// File: rtl/axi_arbiter.sv
// axi_arbiter: shares one single-outstanding AXI bridge between the
// instruction-fetch port and the data port. One pending request is held per
// port; a single grant is issued as a one-cycle axi_valid pulse and the
// bridge completion is routed combinationally back to the owning port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction at the bridge; issues a request if any is pending
// BUSY  | one transaction outstanding; waits for axi_ready from the bridge
module axi_arbiter #(
    parameter int DATA_PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        axi_valid,
    output logic        axi_instr,
    output logic [31:0] axi_addr,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    input  logic [31:0] axi_rdata,
    input  logic        axi_ready
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;
    localparam logic PORT_I  = 1'b0;
    localparam logic PORT_D  = 1'b1;

    logic        state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        ipend_q, ipend_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        dpend_q, dpend_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic [3:0]  dwstrb_q, dwstrb_d;

    logic issue;
    logic grant_data;
    logic icomp;
    logic dcomp;

    // Arbitration and completion decode; data wins a tie under fixed priority
    // or when the instruction port was served last.
    always_comb begin
        issue      = (state_q == ST_IDLE) && (ipend_q || dpend_q);
        grant_data = dpend_q && (!ipend_q || (DATA_PRIORITY != 0) || (last_grant_q == PORT_I));
        icomp      = (state_q == ST_BUSY) && axi_ready && (owner_q == PORT_I);
        dcomp      = (state_q == ST_BUSY) && axi_ready && (owner_q == PORT_D);
    end

    // Bridge request and port completion outputs, all zero outside their pulse.
    always_comb begin
        axi_valid  = issue;
        axi_instr  = issue && !grant_data;
        axi_addr   = 32'h0;
        axi_wdata  = 32'h0;
        axi_wstrb  = 4'h0;
        if (issue) begin
            if (grant_data) begin
                axi_addr  = daddr_q;
                axi_wdata = dwdata_q;
                axi_wstrb = dwstrb_q;
            end else begin
                axi_addr  = iaddr_q;
            end
        end
        imem_ready = icomp;
        imem_rdata = icomp ? axi_rdata : 32'h0;
        dmem_ready = dcomp;
        dmem_rdata = dcomp ? axi_rdata : 32'h0;
    end

    // Next-state for the FSM, owner tracking and the two pending buffers.
    // A new request is only accepted into an empty or completing buffer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ipend_d      = ipend_q;
        iaddr_d      = iaddr_q;
        dpend_d      = dpend_q;
        daddr_d      = daddr_q;
        dwdata_d     = dwdata_q;
        dwstrb_d     = dwstrb_q;

        if (issue) begin
            state_d = ST_BUSY;
            owner_d = grant_data ? PORT_D : PORT_I;
        end else if ((state_q == ST_BUSY) && axi_ready) begin
            state_d      = ST_IDLE;
            last_grant_d = owner_q;
        end

        if (imem_valid && (!ipend_q || icomp)) begin
            ipend_d = 1'b1;
            iaddr_d = imem_addr;
        end else if (icomp) begin
            ipend_d = 1'b0;
        end

        if (dmem_valid && (!dpend_q || dcomp)) begin
            dpend_d  = 1'b1;
            daddr_d  = dmem_addr;
            dwdata_d = dmem_wdata;
            dwstrb_d = dmem_wstrb;
        end else if (dcomp) begin
            dpend_d = 1'b0;
        end
    end

    // State registers; reset abandons any outstanding transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_I;
            ipend_q      <= 1'b0;
            iaddr_q      <= 32'h0;
            dpend_q      <= 1'b0;
            daddr_q      <= 32'h0;
            dwdata_q     <= 32'h0;
            dwstrb_q     <= 4'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ipend_q      <= ipend_d;
            iaddr_q      <= iaddr_d;
            dpend_q      <= dpend_d;
            daddr_q      <= daddr_d;
            dwdata_q     <= dwdata_d;
            dwstrb_q     <= dwstrb_d;
        end
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Bench for axi_arbiter: two instances (round-robin and data priority) share
// the port inputs; each has its own bridge ready. A transaction-level model
// predicts every output each cycle, plus directed scenario checks.
module tb_axi_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        iv, dv;
    logic [31:0] ia, da, wd, ard;
    logic [3:0]  ws;
    logic        rdy [2];

    logic        o_av [2];
    logic        o_ai [2];
    logic [31:0] o_aa [2];
    logic [31:0] o_awd [2];
    logic [3:0]  o_aws [2];
    logic        o_ir [2];
    logic [31:0] o_ird [2];
    logic        o_dr [2];
    logic [31:0] o_drd [2];

    int errors = 0;
    int checks = 0;

    // model state per instance k, per port p (0 = instruction, 1 = data)
    logic        m_pend [2][2];
    logic [31:0] m_addr [2][2];
    logic [31:0] m_wd [2];
    logic [3:0]  m_ws [2];
    logic        m_busy [2];
    int          m_owner [2];
    int          m_last [2];

    logic        log_en = 1'b0;
    logic [7:0]  glog [2];
    int          nlog [2];

    always #5 clock = ~clock;

    axi_arbiter #(.DATA_PRIORITY(0)) u_rr (
        .clock(clock), .reset(reset),
        .imem_valid(iv), .imem_addr(ia), .imem_rdata(o_ird[0]), .imem_ready(o_ir[0]),
        .dmem_valid(dv), .dmem_addr(da), .dmem_wdata(wd), .dmem_wstrb(ws),
        .dmem_rdata(o_drd[0]), .dmem_ready(o_dr[0]),
        .axi_valid(o_av[0]), .axi_instr(o_ai[0]), .axi_addr(o_aa[0]),
        .axi_wdata(o_awd[0]), .axi_wstrb(o_aws[0]),
        .axi_rdata(ard), .axi_ready(rdy[0])
    );

    axi_arbiter #(.DATA_PRIORITY(1)) u_dp (
        .clock(clock), .reset(reset),
        .imem_valid(iv), .imem_addr(ia), .imem_rdata(o_ird[1]), .imem_ready(o_ir[1]),
        .dmem_valid(dv), .dmem_addr(da), .dmem_wdata(wd), .dmem_wstrb(ws),
        .dmem_rdata(o_drd[1]), .dmem_ready(o_dr[1]),
        .axi_valid(o_av[1]), .axi_instr(o_ai[1]), .axi_addr(o_aa[1]),
        .axi_wdata(o_awd[1]), .axi_wstrb(o_aws[1]),
        .axi_rdata(ard), .axi_ready(rdy[1])
    );

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [135:0] outs(input int k);
        return {o_av[k], o_ai[k], o_aa[k], o_awd[k], o_aws[k],
                o_ir[k], o_ird[k], o_dr[k], o_drd[k]};
    endfunction

    // Winner when idle: the only pending port, or on a tie data under
    // priority, else whichever port was not served last.
    function automatic int pick(input int k);
        if (m_pend[k][0] && m_pend[k][1])
            return (k == 1) ? 1 : 1 - m_last[k];
        return m_pend[k][1] ? 1 : 0;
    endfunction

    task automatic model_init();
        for (int k = 0; k < 2; k++) begin
            m_pend[k][0] = 1'b0;
            m_pend[k][1] = 1'b0;
            m_busy[k]    = 1'b0;
            m_owner[k]   = 0;
            m_last[k]    = 0;
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic sample();
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            logic        e_av, e_ai, e_ir, e_dr;
            logic [31:0] e_aa, e_awd, e_ird, e_drd;
            logic [3:0]  e_aws;
            int g;
            e_av = 0; e_ai = 0; e_ir = 0; e_dr = 0;
            e_aa = 0; e_awd = 0; e_ird = 0; e_drd = 0; e_aws = 0;
            if (!m_busy[k]) begin
                if (m_pend[k][0] || m_pend[k][1]) begin
                    g    = pick(k);
                    e_av = 1'b1;
                    e_ai = (g == 0);
                    e_aa = m_addr[k][g];
                    if (g == 1) begin
                        e_awd = m_wd[k];
                        e_aws = m_ws[k];
                    end
                end
            end else if (rdy[k]) begin
                if (m_owner[k] == 0) begin
                    e_ir = 1'b1; e_ird = ard;
                end else begin
                    e_dr = 1'b1; e_drd = ard;
                end
            end
            chk(k == 0 ? "model_rr" : "model_dp", outs(k),
                {e_av, e_ai, e_aa, e_awd, e_aws, e_ir, e_ird, e_dr, e_drd});
            if (log_en && o_av[k] && nlog[k] < 8) begin
                glog[k][nlog[k]] = o_ai[k];
                nlog[k]++;
            end
        end
    endtask

    // Advance the model across the rising edge with the inputs of this cycle.
    task automatic advance();
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            logic comp [2];
            logic v;
            comp[0] = 1'b0;
            comp[1] = 1'b0;
            if (!m_busy[k]) begin
                if (m_pend[k][0] || m_pend[k][1]) begin
                    m_owner[k] = pick(k);
                    m_busy[k]  = 1'b1;
                end
            end else if (rdy[k]) begin
                comp[m_owner[k]] = 1'b1;
                m_last[k] = m_owner[k];
                m_busy[k] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                v = (p == 1) ? dv : iv;
                if (v && (!m_pend[k][p] || comp[p])) begin
                    m_pend[k][p] = 1'b1;
                    m_addr[k][p] = (p == 1) ? da : ia;
                    if (p == 1) begin
                        m_wd[k] = wd;
                        m_ws[k] = ws;
                    end
                end else if (comp[p]) begin
                    m_pend[k][p] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        iv = 0; dv = 0; ia = 0; da = 0; wd = 0; ws = 0; ard = 0;
        rdy[0] = 0; rdy[1] = 0;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic reset_dut();
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("rst_zero_rr", outs(0), 136'h0);
        chk("rst_zero_dp", outs(1), 136'h0);
        model_init();
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        reset_dut();

        // single fetch, then re-request in the completion cycle
        iv = 1; ia = 32'h100;
        tick();
        iv = 0;
        sample();
        chk("fetch_issue", 136'({o_av[0], o_ai[0], o_aa[0], o_aws[0]}),
            136'({1'b1, 1'b1, 32'h100, 4'h0}));
        advance();
        tick();
        tick();
        rdy[0] = 1; rdy[1] = 1; ard = 32'h13; iv = 1; ia = 32'h104;
        sample();
        chk("fetch_done", 136'({o_ir[0], o_ird[0], o_dr[0]}),
            136'({1'b1, 32'h13, 1'b0}));
        advance();
        rdy[0] = 0; rdy[1] = 0; ard = 0; iv = 0;
        sample();
        chk("rereq_issue", 136'({o_av[0], o_ai[0], o_aa[0]}),
            136'({1'b1, 1'b1, 32'h104}));
        advance();
        tick();
        rdy[0] = 1; rdy[1] = 1;
        tick();
        rdy[0] = 0; rdy[1] = 0;

        // tie after reset: data first, instruction after data completes
        reset_dut();
        iv = 1; ia = 32'h100; dv = 1; da = 32'h2000; ws = 0;
        tick();
        iv = 0; dv = 0;
        sample();
        chk("tie_data", 136'({o_av[0], o_ai[0], o_aa[0]}), 136'({1'b1, 1'b0, 32'h2000}));
        advance();
        tick();
        rdy[0] = 1; rdy[1] = 1; ard = 32'h55;
        tick();
        rdy[0] = 0; rdy[1] = 0; ard = 0;
        sample();
        chk("tie_instr", 136'({o_av[0], o_ai[0], o_aa[0]}), 136'({1'b1, 1'b1, 32'h100}));
        advance();
        tick();
        rdy[0] = 1; rdy[1] = 1;
        tick();
        rdy[0] = 0; rdy[1] = 0;

        // write forwarded unchanged; completion returns zero data
        dv = 1; da = 32'h2004; wd = 32'hDEADBEEF; ws = 4'hF;
        tick();
        dv = 0;
        sample();
        chk("wr_issue", 136'({o_av[0], o_ai[0], o_aa[0], o_awd[0], o_aws[0]}),
            136'({1'b1, 1'b0, 32'h2004, 32'hDEADBEEF, 4'hF}));
        advance();
        tick();
        rdy[0] = 1; rdy[1] = 1; ard = 0;
        sample();
        chk("wr_done", 136'({o_dr[0], o_drd[0], o_ir[0]}), 136'({1'b1, 32'h0, 1'b0}));
        advance();
        rdy[0] = 0; rdy[1] = 0; ws = 0;

        // fairness: both ports re-request in every completion cycle
        reset_dut();
        nlog[0] = 0; nlog[1] = 0; glog[0] = 0; glog[1] = 0;
        log_en = 1'b1;
        iv = 1; ia = 32'h100; dv = 1; da = 32'h2000;
        tick();
        iv = 0; dv = 0;
        for (int n = 0; n < 60; n++) begin
            if (nlog[0] >= 8 && nlog[1] >= 8) break;
            rdy[0] = m_busy[0];
            rdy[1] = m_busy[1];
            iv = m_busy[0];
            dv = m_busy[0];
            ia = 32'h100 + 32'(n);
            da = 32'h2000 + 32'(n);
            tick();
        end
        log_en = 1'b0;
        idle_inputs();
        chk("fair_rr", 136'({nlog[0] >= 8, glog[0]}), 136'({1'b1, 8'b1010_1010}));
        chk("fair_dp", 136'({nlog[1] >= 8, glog[1]}), 136'({1'b1, 8'h00}));

        // reset mid-transaction with data outstanding
        reset_dut();
        dv = 1; da = 32'h3000;
        tick();
        dv = 0;
        tick();
        reset_dut();
        for (int n = 0; n < 3; n++) begin
            sample();
            chk("no_spurious", 136'({o_av[0], o_av[1]}), 136'(2'b00));
            advance();
        end
        iv = 1; ia = 32'h400; dv = 1; da = 32'h5000;
        tick();
        iv = 0; dv = 0;
        sample();
        chk("rst_tie", 136'({o_av[0], o_ai[0], o_aa[0]}), 136'({1'b1, 1'b0, 32'h5000}));
        advance();

        // randomized traffic against the model
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            iv  = ($urandom % 4 == 0);
            ia  = $urandom;
            dv  = ($urandom % 4 == 0);
            da  = $urandom;
            wd  = $urandom;
            ws  = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
            ard = $urandom;
            rdy[0] = m_busy[0] && ($urandom % 3 == 0);
            rdy[1] = m_busy[1] && ($urandom % 3 == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
